ex_mem_elastic: RTL and testbench

- Parametrised EX->MEM pipeline boundary for the RISC-V core.
- Adds valid/ready flow control, flush, a 2-entry skid buffer and memory-access fields (op, address, store data) on top of writeback fields (wd, wreg, wdata).
- Lets MEM stall (e.g. on a data-cache miss) without a combinational ready path back into EX, and lets the branch/exception unit squash in-flight instructions.

---
 rtl/ex_mem_elastic_pkg.sv | 35 +++
 rtl/ex_mem_elastic_skid_buf.sv | 86 ++++++++
 rtl/ex_mem_elastic.sv | 73 +++++++
 tb/tb_ex_mem_elastic.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_elastic_pkg.sv
// Shared definitions for the EX->MEM boundary: memory-op encodings, default
// widths and the writeback/memory payload bundle.
package ex_mem_elastic_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int MEMOP_W_DEF    = 4;

    typedef enum logic [MEMOP_W_DEF-1:0] {
        MEMOP_NOP = 4'd0,
        MEMOP_LB  = 4'd1,
        MEMOP_LH  = 4'd2,
        MEMOP_LW  = 4'd3,
        MEMOP_LBU = 4'd4,
        MEMOP_LHU = 4'd5,
        MEMOP_SB  = 4'd6,
        MEMOP_SH  = 4'd7,
        MEMOP_SW  = 4'd8
    } memop_e;

    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] wd;
        logic                      wreg;
        logic [XLEN_DEF-1:0]       wdata;
        memop_e                    op;
        logic [XLEN_DEF-1:0]       addr;
        logic [XLEN_DEF-1:0]       sdata;
    } ex_mem_bundle_t;

    // Flattened payload width; field order is {wd, wreg, wdata, op, addr, sdata}.
    function automatic int bundle_width(input int xlen, input int reg_addr_w, input int memop_w);
        return reg_addr_w + 1 + memop_w + 3 * xlen;
    endfunction

endpackage

// File: rtl/ex_mem_elastic_skid_buf.sv
// Generic valid/ready register stage with optional 2-entry skid and flush.
//   state    | meaning
//   ST_EMPTY | nothing held; ready=1, out_valid=0
//   ST_FULL  | main register valid; ready=1
//   ST_SKID  | main and skid registers valid; ready=0 (registered)
module ex_mem_elastic_skid_buf #(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

    state_e       state;
    logic [W-1:0] m_q;
    logic [W-1:0] s_q;
    logic         valid_q;
    logic         ready_q;
    logic         in_xfer;
    logic         out_xfer;

    // Without the skid entry, ready must see MEM's ready in the same cycle.
    assign in_ready  = SKID ? ready_q : (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data  = m_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        m_q     <= in_data;
                        valid_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        m_q <= in_data;
                    end else if (out_xfer) begin
                        valid_q <= 1'b0;
                        state   <= ST_EMPTY;
                    end else if (in_xfer) begin
                        s_q     <= in_data;
                        ready_q <= 1'b0;
                        state   <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        m_q     <= s_q;
                        ready_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_elastic.sv
// EX->MEM pipeline boundary: elastic skid stage plus invalid-output gating
// and a saturating MEM stall counter.
module ex_mem_elastic
    import ex_mem_elastic_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEMOP_W     = MEMOP_W_DEF,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [REG_ADDR_W-1:0]  ex_wd,
    input  logic                   ex_wreg,
    input  logic [XLEN-1:0]        ex_wdata,
    input  logic [MEMOP_W-1:0]     ex_mem_op,
    input  logic [XLEN-1:0]        ex_mem_addr,
    input  logic [XLEN-1:0]        ex_mem_sdata,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [REG_ADDR_W-1:0]  mem_wd,
    output logic                   mem_wreg,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [MEMOP_W-1:0]     mem_op,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_sdata,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int BW = bundle_width(XLEN, REG_ADDR_W, MEMOP_W);
    localparam logic [MEMOP_W-1:0] OP_NOP = MEMOP_W'(MEMOP_NOP);

    logic [BW-1:0]      in_bundle;
    logic [BW-1:0]      out_bundle;
    logic               m_wreg;
    logic [MEMOP_W-1:0] m_op;

    assign in_bundle = {ex_wd, ex_wreg, ex_wdata, ex_mem_op, ex_mem_addr, ex_mem_sdata};

    ex_mem_elastic_skid_buf #(
        .W    (BW),
        .SKID (SKID != 0)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_bundle),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (out_bundle)
    );

    assign {mem_wd, m_wreg, mem_wdata, m_op, mem_addr, mem_sdata} = out_bundle;

    // Side-effecting fields are gated so a squashed or empty slot is harmless.
    assign mem_wreg = m_wreg & mem_valid;
    assign mem_op   = mem_valid ? m_op : OP_NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (mem_valid && !mem_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Scoreboard bench for ex_mem_elastic: FIFO reference model for the skid
// build, plus directed runs on a narrow-counter build and a pass-through build.
module tb_ex_mem_elastic;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
    } bundle_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main DUT (SKID=1, 16-bit counter) ----------------
    logic        rst, flush, ex_valid, ex_ready, ex_wreg, mem_valid, mem_ready, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, ex_mem_addr, ex_mem_sdata, mem_wdata, mem_addr, mem_sdata;
    logic [3:0]  ex_mem_op, mem_op;
    logic [15:0] stall_cnt;

    ex_mem_elastic u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_wdata(ex_wdata), .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
        .ex_mem_sdata(ex_mem_sdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata), .stall_cnt(stall_cnt)
    );

    // ---------------- saturation DUT (STALL_CNT_W=4) ----------------
    logic        s_rst, s_ex_valid, s_ex_ready, s_mem_valid, s_mem_ready, s_mem_wreg;
    logic [4:0]  s_mem_wd;
    logic [31:0] s_mem_wdata, s_mem_addr, s_mem_sdata;
    logic [3:0]  s_mem_op, s_stall_cnt;

    ex_mem_elastic #(.STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst(s_rst), .flush(1'b0),
        .ex_valid(s_ex_valid), .ex_ready(s_ex_ready), .ex_wd(5'd7), .ex_wreg(1'b1),
        .ex_wdata(32'h77), .ex_mem_op(4'd3), .ex_mem_addr(32'h1000),
        .ex_mem_sdata(32'h0), .mem_valid(s_mem_valid), .mem_ready(s_mem_ready),
        .mem_wd(s_mem_wd), .mem_wreg(s_mem_wreg), .mem_wdata(s_mem_wdata), .mem_op(s_mem_op),
        .mem_addr(s_mem_addr), .mem_sdata(s_mem_sdata), .stall_cnt(s_stall_cnt)
    );

    // ---------------- pass-through DUT (SKID=0) ----------------
    logic        c_rst, c_ex_valid, c_ex_ready, c_mem_valid, c_mem_ready, c_mem_wreg;
    logic [4:0]  c_ex_wd, c_mem_wd;
    logic [31:0] c_mem_wdata, c_mem_addr, c_mem_sdata;
    logic [3:0]  c_mem_op;
    logic [15:0] c_stall_cnt;

    ex_mem_elastic #(.SKID(0)) u_comb (
        .clk(clk), .rst(c_rst), .flush(1'b0),
        .ex_valid(c_ex_valid), .ex_ready(c_ex_ready), .ex_wd(c_ex_wd), .ex_wreg(1'b1),
        .ex_wdata(32'hAB), .ex_mem_op(4'd8), .ex_mem_addr(32'h2000),
        .ex_mem_sdata(32'h5A5A), .mem_valid(c_mem_valid), .mem_ready(c_mem_ready),
        .mem_wd(c_mem_wd), .mem_wreg(c_mem_wreg), .mem_wdata(c_mem_wdata), .mem_op(c_mem_op),
        .mem_addr(c_mem_addr), .mem_sdata(c_mem_sdata), .stall_cnt(c_stall_cnt)
    );

    // Reference model: a 2-deep FIFO of accepted bundles; head drives MEM.
    bundle_t q[$];
    int      exp_stall = 0;
    bit      mon_en    = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
                chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
                if (!mem_valid) begin
                    chk("mem_wreg_gated", 64'(mem_wreg), 64'(0));
                    chk("mem_op_gated", 64'(mem_op), 64'(0));
                end else if (q.size() != 0) begin
                    chk("mem_wd", 64'(mem_wd), 64'(q[0].wd));
                    chk("mem_wreg", 64'(mem_wreg), 64'(q[0].wreg));
                    chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
                    chk("mem_op", 64'(mem_op), 64'(q[0].op));
                    chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
                    chk("mem_sdata", 64'(mem_sdata), 64'(q[0].sdata));
                end
                chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
                if (mem_valid && !mem_ready && exp_stall < 65535) exp_stall++;
                if (mem_valid && mem_ready && q.size() != 0) void'(q.pop_front());
                if (flush) q.delete();
            end
        end
    end

    task automatic cycle(input logic v, input bundle_t b, input logic mrdy, input logic fl);
        @(negedge clk);
        ex_valid     = v;
        ex_wd        = b.wd;
        ex_wreg      = b.wreg;
        ex_wdata     = b.wdata;
        ex_mem_op    = b.op;
        ex_mem_addr  = b.addr;
        ex_mem_sdata = b.sdata;
        mem_ready    = mrdy;
        flush        = fl;
        #2;
        if (v && ex_ready && !fl) q.push_back(b);
    endtask

    function automatic bundle_t mk(input int wd, input int wdata, input int op);
        bundle_t b;
        b.wd    = 5'(wd);
        b.wreg  = (op < 6);
        b.wdata = 32'(wdata);
        b.op    = 4'(op);
        b.addr  = 32'h8000_0000 + 32'(wd * 4);
        b.sdata = 32'hCAFE_0000 + 32'(wdata);
        return b;
    endfunction

    function automatic bundle_t rnd();
        bundle_t b;
        b.wd    = 5'($urandom_range(0, 31));
        b.wreg  = 1'($urandom_range(0, 1));
        b.wdata = $urandom;
        b.op    = 4'($urandom_range(0, 8));
        b.addr  = $urandom;
        b.sdata = $urandom;
        return b;
    endfunction

    initial begin
        bundle_t idle;
        int      s_exp;
        idle = mk(0, 0, 0);

        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_mem_op = '0; ex_mem_addr = '0; ex_mem_sdata = '0;
        s_rst = 1'b1; s_ex_valid = 1'b0; s_mem_ready = 1'b1;
        c_rst = 1'b1; c_ex_valid = 1'b0; c_mem_ready = 1'b1; c_ex_wd = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #3;
        chk("reset_wd", 64'(mem_wd), 64'(0));
        chk("reset_wdata", 64'(mem_wdata), 64'(0));
        chk("reset_addr", 64'(mem_addr), 64'(0));
        chk("reset_sdata", 64'(mem_sdata), 64'(0));
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Streaming: 8 back-to-back bundles, no backpressure.
        for (int i = 1; i <= 8; i++) cycle(1'b1, mk(i, 32'h100 + i, i % 9), 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Stall into skid, then drain in order.
        cycle(1'b1, mk(3, 32'h33, 3), 1'b0, 1'b0);
        cycle(1'b1, mk(4, 32'h44, 1), 1'b0, 1'b0);
        cycle(1'b1, mk(20, 32'h55, 2), 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Flush while in SKID with a simultaneous SW bundle on EX.
        cycle(1'b1, mk(5, 32'h5, 3), 1'b0, 1'b0);
        cycle(1'b1, mk(6, 32'h6, 6), 1'b0, 1'b0);
        cycle(1'b1, mk(9, 32'h9, 8), 1'b0, 1'b1);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 9) < 7), rnd(), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1, 1'b0);

        // Stall counter saturation on the 4-bit build.
        @(negedge clk);
        s_rst = 1'b0;
        s_exp = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            s_ex_valid  = (i == 0);
            s_mem_ready = 1'b0;
            #3;
            chk("sat_mem_valid", 64'(s_mem_valid), 64'(i > 0));
            chk("sat_stall_cnt", 64'(s_stall_cnt), 64'(s_exp));
            if (i > 0) s_exp = (s_exp == 15) ? 15 : s_exp + 1;
        end
        chk("sat_final", 64'(s_stall_cnt), 64'(15));
        chk("sat_held_wd", 64'(s_mem_wd), 64'(7));

        // Pass-through build: ready follows mem_ready combinationally when full.
        @(negedge clk);
        c_rst = 1'b0;
        @(negedge clk);
        c_ex_valid = 1'b1; c_ex_wd = 5'd11; c_mem_ready = 1'b1;
        #3;
        chk("comb_ready_empty", 64'(c_ex_ready), 64'(1));
        @(negedge clk);
        c_ex_valid = 1'b0; c_mem_ready = 1'b0;
        #3;
        chk("comb_valid", 64'(c_mem_valid), 64'(1));
        chk("comb_wd", 64'(c_mem_wd), 64'(11));
        chk("comb_op", 64'(c_mem_op), 64'(8));
        chk("comb_ready_stall", 64'(c_ex_ready), 64'(0));
        c_mem_ready = 1'b1;
        #1;
        chk("comb_ready_pass", 64'(c_ex_ready), 64'(1));
        c_mem_ready = 1'b0;
        @(negedge clk);
        c_ex_valid = 1'b1; c_ex_wd = 5'd12;
        #3;
        chk("comb_stall_cnt", 64'(c_stall_cnt), 64'(1));
        c_rst = 1'b1;
        @(negedge clk);
        #3;
        chk("comb_rst_valid", 64'(c_mem_valid), 64'(0));
        chk("comb_rst_wd", 64'(c_mem_wd), 64'(0));
        chk("comb_rst_wreg", 64'(c_mem_wreg), 64'(0));
        chk("comb_rst_wdata", 64'(c_mem_wdata), 64'(0));
        chk("comb_rst_op", 64'(c_mem_op), 64'(0));
        chk("comb_rst_addr", 64'(c_mem_addr), 64'(0));
        chk("comb_rst_sdata", 64'(c_mem_sdata), 64'(0));
        chk("comb_rst_stall", 64'(c_stall_cnt), 64'(0));
        chk("comb_rst_ready", 64'(c_ex_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
